// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller with level/almost flags and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is one-cycle registered read.
module sync_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int LW      = $clog2(DEPTH + 1),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [LW-1:0]     level,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_acc;
    logic              w_rd_acc;

    // Flags decode the registered level only, so requests never reach them combinationally.
    assign full         = (r_level == LW'(DEPTH));
    assign empty        = (r_level == '0);
    assign almost_full  = (r_level >= LW'(AF_LEVEL));
    assign almost_empty = (r_level <= LW'(AE_LEVEL));
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr_en && !full;
    assign w_rd_acc = rd_en && !empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always on the output; rd_en only acknowledges the pop.
    assign rd_data  = r_mem[r_rd_ptr];
    assign rd_valid = !empty;
`else
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

endmodule
